spi_byte_master: RTL and testbench

//  Byte-level SPI master engine, directly downstream of the converter command driver.
//  - Accepts one byte at a time over a valid/ready handshake.
//  - Serialises each byte MSB-first on MOSI and samples MISO into a received byte.
//  - Frames i_TX_Count bytes under one chip-select assertion.
//  - Serves both the LTC2668 DAC and the LTC2494 ADC (24-bit frames = 3 bytes).

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_clk_gen.sv | 49 ++++
 rtl/spi_byte_master.sv | 165 ++++++++++++++++
 tb/tb_spi_byte_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI byte master.
// FSM states, SPI mode decode and width constants.
package spi_pkg;

  localparam int BYTE_W  = 8;
  localparam int COUNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    WAIT_NEXT,
    CS_HOLD,
    CS_IDLE
  } spi_state_t;

  function automatic logic cpol(
    input logic [1:0] mode
  );
    return mode[1];
  endfunction

  function automatic logic cpha(
    input logic [1:0] mode
  );
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-bit divider plus 16-edge counter.
// Strobes coincide with the clock edge that toggles SCLK.
module spi_clk_gen #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter bit CPOL              = 1'b0
) (
  input  logic i_FPGA_clk,
  input  logic i_FPGA_rst,
  input  logic en,
  output logic lead,
  output logic trail,
  output logic last,
  output logic done,
  output logic sclk
);

  localparam int DIV_W =
    $clog2(CLKS_PER_HALF_BIT);
  localparam logic [DIV_W-1:0] DIV_END =
    DIV_W'(CLKS_PER_HALF_BIT - 1);

  logic [DIV_W-1:0] div;
  logic [4:0]       edges;
  logic             tick;

  assign tick  = en & ~done & (div == DIV_END);
  assign lead  = tick & ~edges[0];
  assign trail = tick & edges[0];
  assign last  = tick & (edges == 5'd15);

  always_ff @(posedge i_FPGA_clk) begin
    if (i_FPGA_rst || !en) begin
      div   <= '0;
      edges <= '0;
      done  <= 1'b0;
      sclk  <= CPOL;
    end else if (!done) begin
      if (tick) begin
        div   <= '0;
        edges <= edges + 5'd1;
        sclk  <= ~sclk;
        done  <= (edges == 5'd15);
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_byte_master.sv
// Byte-level SPI master: valid/ready byte intake, MSB-first
// shifting, multi-byte framing under one CS_n assertion.
module spi_byte_master
  import spi_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int SPI_MODE          = 0,
  parameter int CS_SETUP_CLKS     = 2,
  parameter int CS_HOLD_CLKS      = 2,
  parameter int CS_IDLE_CLKS      = 4
) (
  input  logic               i_FPGA_clk,
  input  logic               i_FPGA_rst,
  input  logic [COUNT_W-1:0] i_TX_Count,
  input  logic [BYTE_W-1:0]  i_TX_Byte,
  input  logic               i_TX_DV,
  output logic               o_TX_Ready,
  output logic               o_RX_DV,
  output logic [BYTE_W-1:0]  o_RX_Byte,
  output logic               o_SPI_Clk,
  input  logic               i_SPI_MISO,
  output logic               o_SPI_MOSI,
  output logic               o_SPI_CS_n
);

  localparam logic CPOL = cpol(2'(SPI_MODE));
  localparam logic CPHA = cpha(2'(SPI_MODE));

  localparam logic [7:0] SETUP_END =
    8'(CS_SETUP_CLKS);
  localparam logic [7:0] HOLD_END =
    8'((CS_HOLD_CLKS > 1) ? CS_HOLD_CLKS - 2 : 0);
  localparam logic [7:0] IDLE_END =
    8'((CS_IDLE_CLKS > 0) ? CS_IDLE_CLKS - 1 : 0);

  spi_state_t         state;
  logic [BYTE_W-1:0]  tx_sr;
  logic [BYTE_W-1:0]  rx_sr;
  logic [7:0]         tmr;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] byte_cnt;

  logic accept;
  logic lead;
  logic trail;
  logic last;
  logic done;
  logic sample;
  logic drive;

  assign accept = i_TX_DV & o_TX_Ready;
  assign sample = CPHA ? trail : lead;
  // no MOSI update after the final edge of a byte
  assign drive  = CPHA ? lead : (trail & ~last);

  spi_clk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT),
    .CPOL             (CPOL)
  ) u_clk_gen (
    .i_FPGA_clk(i_FPGA_clk),
    .i_FPGA_rst(i_FPGA_rst),
    .en        (state == SHIFT),
    .lead      (lead),
    .trail     (trail),
    .last      (last),
    .done      (done),
    .sclk      (o_SPI_Clk)
  );

  always_ff @(posedge i_FPGA_clk) begin
    if (i_FPGA_rst) begin
      state      <= IDLE;
      o_TX_Ready <= 1'b1;
      o_RX_DV    <= 1'b0;
      o_RX_Byte  <= '0;
      o_SPI_MOSI <= 1'b0;
      o_SPI_CS_n <= 1'b1;
      tx_sr      <= '0;
      rx_sr      <= '0;
      tmr        <= '0;
      count      <= '0;
      byte_cnt   <= '0;
    end else begin
      o_RX_DV <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state      <= CS_SETUP;
            tx_sr      <= i_TX_Byte;
            count      <= (i_TX_Count == '0) ?
                          COUNT_W'(1) : i_TX_Count;
            byte_cnt   <= '0;
            tmr        <= '0;
            o_TX_Ready <= 1'b0;
            o_SPI_CS_n <= 1'b0;
          end
        end
        CS_SETUP: begin
          if (tmr == SETUP_END) begin
            state <= SHIFT;
            tmr   <= '0;
            if (!CPHA) begin
              o_SPI_MOSI <= tx_sr[BYTE_W-1];
              tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
            end
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        SHIFT: begin
          if (sample) begin
            rx_sr <= {rx_sr[BYTE_W-2:0], i_SPI_MISO};
          end
          if (drive) begin
            o_SPI_MOSI <= tx_sr[BYTE_W-1];
            tx_sr <= {tx_sr[BYTE_W-2:0], 1'b0};
          end
          if (done) begin
            o_RX_DV   <= 1'b1;
            o_RX_Byte <= rx_sr;
            byte_cnt  <= byte_cnt + COUNT_W'(1);
            tmr       <= '0;
            if (byte_cnt + COUNT_W'(1) == count) begin
              state <= CS_HOLD;
            end else begin
              state      <= WAIT_NEXT;
              o_TX_Ready <= 1'b1;
            end
          end
        end
        WAIT_NEXT: begin
          if (accept) begin
            state      <= SHIFT;
            o_TX_Ready <= 1'b0;
            if (!CPHA) begin
              o_SPI_MOSI <= i_TX_Byte[BYTE_W-1];
              tx_sr <= {i_TX_Byte[BYTE_W-2:0], 1'b0};
            end else begin
              tx_sr <= i_TX_Byte;
            end
          end
        end
        CS_HOLD: begin
          if (tmr == HOLD_END) begin
            state      <= CS_IDLE;
            o_SPI_CS_n <= 1'b1;
            tmr        <= '0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        CS_IDLE: begin
          if (tmr == IDLE_END) begin
            state      <= IDLE;
            o_TX_Ready <= 1'b1;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Randomized bench for spi_byte_master, all four SPI modes,
// checked against a protocol-level slave and timing model.
module tb_spi_byte_master;

  localparam int H  = 2;
  localparam int S  = 2;
  localparam int CH = 2;
  localparam int CI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       dv_s = 1'b0;
  logic [7:0] txb = '0;
  logic [4:0] cnt = '0;
  logic [1:0] sel = '0;
  logic       loopback = 1'b0;
  logic       s_miso = 1'b0;

  wire [3:0] dv, miso, rdy, rxdv, sclk, mosi, csn;
  wire [7:0] rxb [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    assign dv[g] = dv_s && (sel == 2'(g));
    assign miso[g] = (loopback && sel == 2'(g)) ?
                     mosi[g] : s_miso;
    spi_byte_master #(
      .CLKS_PER_HALF_BIT(H),
      .SPI_MODE         (g),
      .CS_SETUP_CLKS    (S),
      .CS_HOLD_CLKS     (CH),
      .CS_IDLE_CLKS     (CI)
    ) u_dut (
      .i_FPGA_clk(clk),
      .i_FPGA_rst(rst),
      .i_TX_Count(cnt),
      .i_TX_Byte (txb),
      .i_TX_DV   (dv[g]),
      .o_TX_Ready(rdy[g]),
      .o_RX_DV   (rxdv[g]),
      .o_RX_Byte (rxb[g]),
      .o_SPI_Clk (sclk[g]),
      .i_SPI_MISO(miso[g]),
      .o_SPI_MOSI(mosi[g]),
      .o_SPI_CS_n(csn[g])
    );
  end

  wire       sclk_s = sclk[sel];
  wire       mosi_s = mosi[sel];
  wire       csn_s  = csn[sel];
  wire       rdy_s  = rdy[sel];
  wire       rxdv_s = rxdv[sel];
  wire [7:0] rxb_s  = rxb[sel];
  wire       cpol_s = sel[1];
  wire       cpha_s = sel[0];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] tx_bytes [32];
  logic [7:0] slave_byte = 8'h5A;
  logic [7:0] rx_q [$];
  logic [7:0] mon_q [$];
  int t_first [32];
  int t_last  [32];
  int t_rxdv  [32];
  int t_acc   [32];
  int edge_n = 0, rises = 0, cs_falls = 0;
  int unstable = 0, t_csrise = -1, t_rdy = -1;
  int s_bits = 0, sh = 0;
  logic [7:0] s_sr = '0, mon_b = '0;
  logic p_sclk = 1'b0, p_cs = 1'b1;
  logic p_rdy = 1'b1, p_mosi = 1'b0;

  // SPI slave plus bus monitor on the selected instance
  always @(negedge clk) begin
    if (p_cs && !csn_s) begin
      cs_falls++;
      edge_n = 0;
      s_bits = 0;
      sh = 0;
      s_sr = slave_byte;
      if (!cpha_s) s_miso = s_sr[7];
    end
    if (!p_cs && csn_s) t_csrise = cyc;
    if (!p_rdy && rdy_s && csn_s) t_rdy = cyc;
    if (sclk_s != p_sclk) begin
      if (!p_sclk) rises++;
      if (edge_n < 512) begin
        if (edge_n % 16 == 0) t_first[(edge_n/16)%32] = cyc;
        if (edge_n % 16 == 15) t_last[(edge_n/16)%32] = cyc;
      end
      if ((p_sclk == cpol_s) != cpha_s) begin
        if (mosi_s != p_mosi) unstable++;
        mon_b = {mon_b[6:0], mosi_s};
        s_bits++;
        if (s_bits == 8) begin
          mon_q.push_back(mon_b);
          s_bits = 0;
        end
      end else if (!cpha_s) begin
        sh++;
        if (sh == 8) begin
          sh = 0;
          s_sr = slave_byte;
        end else begin
          s_sr = {s_sr[6:0], 1'b0};
        end
        s_miso = s_sr[7];
      end else begin
        s_miso = s_sr[7];
        s_sr = {s_sr[6:0], 1'b0};
        sh++;
        if (sh == 8) begin
          sh = 0;
          s_sr = slave_byte;
        end
      end
      edge_n++;
    end
    if (rxdv_s) begin
      if (rx_q.size() < 32) t_rxdv[rx_q.size()] = cyc;
      rx_q.push_back(rxb_s);
    end
    p_sclk = sclk_s;
    p_cs   = csn_s;
    p_rdy  = rdy_s;
    p_mosi = mosi_s;
  end

  task automatic clear_mon();
    rx_q.delete();
    mon_q.delete();
    edge_n = 0;
    rises = 0;
    cs_falls = 0;
    unstable = 0;
    t_csrise = -1;
    t_rdy = -1;
  endtask

  task automatic run_frame(input logic [1:0] m,
                           input int count_val,
                           input bit loop,
                           input bit garbage,
                           input int gap);
    int n, bud, gap_bad;
    n = (count_val == 0) ? 1 : count_val;
    sel = m;
    loopback = loop;
    repeat (3) @(negedge clk);
    clear_mon();
    gap_bad = 0;
    for (int k = 0; k < n; k++) begin
      bud = 0;
      while (!rdy_s && bud < 5000) begin
        dv_s = garbage;
        txb = 8'($urandom);
        cnt = 5'($urandom);
        @(negedge clk);
        bud++;
      end
      chk("ready_wait", int'(rdy_s), 1);
      if (k == 1 && gap > 0) begin
        dv_s = 1'b0;
        repeat (gap) begin
          @(negedge clk);
          if (csn_s !== 1'b0 || sclk_s !== cpol_s)
            gap_bad++;
        end
      end
      dv_s = 1'b1;
      txb = tx_bytes[k];
      cnt = (k == 0) ? 5'(count_val) : 5'($urandom);
      @(negedge clk);
      t_acc[k] = cyc;
      dv_s = garbage;
      txb = 8'($urandom);
    end
    bud = 0;
    while (!(csn_s && rdy_s) && bud < 5000) begin
      dv_s = garbage;
      txb = 8'($urandom);
      @(negedge clk);
      bud++;
    end
    dv_s = 1'b0;
    chk("frame_end", int'(csn_s && rdy_s), 1);
    repeat (3) @(negedge clk);
    if (gap > 0) chk("gap_idle", gap_bad, 0);
    chk("rx_count", rx_q.size(), n);
    chk("mosi_count", mon_q.size(), n);
    chk("sclk_rises", rises, 8 * n);
    chk("cs_falls", cs_falls, 1);
    chk("mosi_stable", unstable, 0);
    chk("sclk_idle", int'(sclk_s), int'(cpol_s));
    for (int k = 0; k < n; k++) begin
      if (k < rx_q.size())
        chk("rx_byte", rx_q[k],
            loop ? tx_bytes[k] : slave_byte);
      if (k < mon_q.size())
        chk("mosi_byte", mon_q[k], tx_bytes[k]);
      chk("first_edge_lat", t_first[k] - t_acc[k],
          (k == 0) ? 1 + S + H : H);
      if (k < rx_q.size())
        chk("rxdv_lat", t_rxdv[k] - t_last[k], 1);
    end
    chk("cs_hold", t_csrise - t_last[n-1], CH);
    chk("cs_idle", t_rdy - t_csrise, CI);
  endtask

  initial begin
    int bud, r0;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      chk("rst_ready", int'(rdy[m]), 1);
      chk("rst_rxdv", int'(rxdv[m]), 0);
      chk("rst_rxbyte", int'(rxb[m]), 0);
      chk("rst_sclk", int'(sclk[m]), m >> 1);
      chk("rst_mosi", int'(mosi[m]), 0);
      chk("rst_csn", int'(csn[m]), 1);
    end
    rst = 1'b0;

    tx_bytes[0] = 8'hA5;
    tx_bytes[1] = 8'h3C;
    tx_bytes[2] = 8'hFF;
    run_frame(2'd0, 3, 1'b1, 1'b0, 0);

    slave_byte = 8'h5A;
    tx_bytes[0] = 8'h81;
    for (int m = 1; m < 4; m++)
      run_frame(2'(m), 1, 1'b0, 1'b0, 0);

    slave_byte = 8'($urandom);
    tx_bytes[0] = 8'h12;
    run_frame(2'd0, 0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 32; k++)
      tx_bytes[k] = 8'($urandom);
    run_frame(2'd0, 3, 1'b0, 1'b1, 0);
    run_frame(2'd3, 2, 1'b0, 1'b1, 0);
    run_frame(2'd0, 3, 1'b0, 1'b0, 50);

    repeat (8) begin
      for (int k = 0; k < 32; k++)
        tx_bytes[k] = 8'($urandom);
      slave_byte = 8'($urandom);
      run_frame(2'($urandom), $urandom_range(0, 5),
                1'($urandom), 1'($urandom),
                $urandom_range(0, 10));
    end

    for (int k = 0; k < 32; k++)
      tx_bytes[k] = 8'($urandom);
    run_frame(2'($urandom), 31, 1'b0, 1'b0, 0);

    sel = 2'd0;
    loopback = 1'b0;
    repeat (3) @(negedge clk);
    clear_mon();
    dv_s = 1'b1;
    txb = 8'hA5;
    cnt = 5'd1;
    @(negedge clk);
    dv_s = 1'b0;
    bud = 0;
    while (edge_n < 8 && bud < 1000) begin
      @(negedge clk);
      bud++;
    end
    chk("rst_reach_bit4", int'(edge_n >= 8), 1);
    rst = 1'b1;
    @(negedge clk);
    r0 = rises;
    chk("midrst_csn", int'(csn_s), 1);
    chk("midrst_sclk", int'(sclk_s), 0);
    chk("midrst_ready", int'(rdy_s), 1);
    chk("midrst_rxdv", int'(rxdv_s), 0);
    chk("midrst_mosi", int'(mosi_s), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_no_rx", rx_q.size(), 0);
    chk("midrst_no_edge", rises, r0);
    tx_bytes[0] = 8'h3C;
    run_frame(2'd0, 1, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
